// File: rtl/vc_state_tracker.sv
// vc_state_tracker
// Registered per-output-port, per-VC lifecycle and credit tracker.
// Every VC on every output port has a three-state lifecycle
// (IDLE -> ACTIVE -> WAIT_FREE -> IDLE) and a downstream credit counter.
// Events arrive as valid-qualified one-cycle pulses (valid high = event
// happens at the next posedge). There is no ready and no back-pressure:
// every presented event is consumed, and illegal ones are recorded in a
// sticky per-port error flag.
// All outputs are decoded from registered state only. An event in cycle t
// is therefore visible in cycle t+1, and no input reaches an output
// combinationally.
module vc_state_tracker #(
    parameter  int NUM_PORTS = 5,
    parameter  int NUM_VCS   = 4,
    parameter  int BUF_DEPTH = 4,
    localparam int VW        = $clog2(NUM_VCS),
    localparam int CW        = $clog2(BUF_DEPTH + 1),
    localparam int FCW       = $clog2(NUM_VCS + 1)
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NUM_PORTS-1:0]           alloc_valid,
    input  logic [NUM_PORTS*VW-1:0]        alloc_vc,
    input  logic [NUM_PORTS-1:0]           send_valid,
    input  logic [NUM_PORTS*VW-1:0]        send_vc,
    input  logic [NUM_PORTS-1:0]           send_tail,
    input  logic [NUM_PORTS-1:0]           cred_valid,
    input  logic [NUM_PORTS*VW-1:0]        cred_vc,
    input  logic [NUM_PORTS-1:0]           cred_free,
    output logic [NUM_PORTS*NUM_VCS-1:0]   vc_available,
    output logic [NUM_PORTS*NUM_VCS-1:0]   credit_avail,
    output logic [NUM_PORTS*VW-1:0]        next_free_vc,
    output logic [NUM_PORTS-1:0]           next_free_valid,
    output logic [NUM_PORTS*FCW-1:0]       free_vc_count,
    output logic [NUM_PORTS-1:0]           err_sticky,
    // Debug view of every VC lifecycle state, 2 bits per VC at [(p*NUM_VCS+v)*2+:2]
    output logic [NUM_PORTS*NUM_VCS*2-1:0] vc_state_dbg
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_WAIT_FREE = 2'd2
    } vc_state_e;

    vc_state_e            state_q [NUM_PORTS][NUM_VCS];
    vc_state_e            state_d [NUM_PORTS][NUM_VCS];
    logic [CW-1:0]        cred_q  [NUM_PORTS][NUM_VCS];
    logic [CW-1:0]        cred_d  [NUM_PORTS][NUM_VCS];
    logic [NUM_PORTS-1:0] err_q;
    logic [NUM_PORTS-1:0] err_d;

    // A VC id is usable only if it names an existing VC (matters when NUM_VCS is not a power of 2).
    function automatic logic id_ok(input logic [VW-1:0] id);
        return ({1'b0, id} < (VW + 1)'(NUM_VCS));
    endfunction

    // State register: reset puts every VC IDLE with a full credit count and clears errors.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int p = 0; p < NUM_PORTS; p++) begin
                for (int v = 0; v < NUM_VCS; v++) begin
                    state_q[p][v] <= ST_IDLE;
                    cred_q[p][v]  <= CW'(BUF_DEPTH);
                end
            end
            err_q <= '0;
        end else begin
            state_q <= state_d;
            cred_q  <= cred_d;
            err_q   <= err_d;
        end
    end

    // Next-state: resolve alloc/send/credit events per VC against start-of-cycle state.
    always_comb begin
        logic [VW-1:0] a_id;
        logic [VW-1:0] s_id;
        logic [VW-1:0] c_id;
        logic          a_ok;
        logic          s_ok;
        logic          c_ok;
        logic          a_hit;
        logic          s_hit;
        logic          c_hit;
        logic          f_hit;
        a_id    = '0;
        s_id    = '0;
        c_id    = '0;
        a_ok    = 1'b0;
        s_ok    = 1'b0;
        c_ok    = 1'b0;
        a_hit   = 1'b0;
        s_hit   = 1'b0;
        c_hit   = 1'b0;
        f_hit   = 1'b0;
        state_d = state_q;
        cred_d  = cred_q;
        err_d   = err_q;
        for (int p = 0; p < NUM_PORTS; p++) begin
            a_id = alloc_vc[p*VW+:VW];
            s_id = send_vc[p*VW+:VW];
            c_id = cred_vc[p*VW+:VW];
            a_ok = id_ok(a_id);
            s_ok = id_ok(s_id);
            c_ok = id_ok(c_id);
            // An out-of-range id drops the whole event and only raises the error.
            if ((alloc_valid[p] && !a_ok) || (send_valid[p] && !s_ok) ||
                (cred_valid[p] && !c_ok)) begin
                err_d[p] = 1'b1;
            end
            for (int v = 0; v < NUM_VCS; v++) begin
                a_hit = alloc_valid[p] && a_ok && (a_id == VW'(v));
                s_hit = send_valid[p]  && s_ok && (s_id == VW'(v));
                c_hit = cred_valid[p]  && c_ok && (c_id == VW'(v));
                f_hit = c_hit && cred_free[p];
                // Lifecycle: an event illegal for the current state is dropped and flagged.
                unique case (state_q[p][v])
                    ST_IDLE: begin
                        if (a_hit) state_d[p][v] = ST_ACTIVE;
                        if (s_hit || f_hit) err_d[p] = 1'b1;
                    end
                    ST_ACTIVE: begin
                        if (s_hit && send_tail[p]) state_d[p][v] = ST_WAIT_FREE;
                        if (a_hit || f_hit) err_d[p] = 1'b1;
                    end
                    ST_WAIT_FREE: begin
                        if (f_hit) state_d[p][v] = ST_IDLE;
                        if (a_hit || s_hit) err_d[p] = 1'b1;
                    end
                    default: begin
                        state_d[p][v] = ST_IDLE;
                        err_d[p]      = 1'b1;
                    end
                endcase
                // Credits move independently of the lifecycle; a same-cycle send and return cancel.
                if (c_hit && !s_hit) begin
                    if (cred_q[p][v] == CW'(BUF_DEPTH)) err_d[p] = 1'b1;
                    else cred_d[p][v] = cred_q[p][v] + CW'(1);
                end else if (s_hit && !c_hit) begin
                    if (cred_q[p][v] == '0) err_d[p] = 1'b1;
                    else cred_d[p][v] = cred_q[p][v] - CW'(1);
                end
            end
        end
    end

    // Output decode from registered state: availability, credit flags, lowest free VC, popcount.
    always_comb begin
        logic [FCW-1:0] cnt;
        logic [VW-1:0]  enc;
        logic           idle;
        cnt             = '0;
        enc             = '0;
        idle            = 1'b0;
        vc_available    = '0;
        credit_avail    = '0;
        next_free_vc    = '0;
        next_free_valid = '0;
        free_vc_count   = '0;
        vc_state_dbg    = '0;
        for (int p = 0; p < NUM_PORTS; p++) begin
            cnt = '0;
            enc = '0;
            // Walk downward so the lowest-index IDLE VC is the one left in enc.
            for (int v = NUM_VCS - 1; v >= 0; v--) begin
                idle = (state_q[p][v] == ST_IDLE);
                vc_available[p*NUM_VCS+v]     = idle;
                credit_avail[p*NUM_VCS+v]     = (cred_q[p][v] != '0);
                vc_state_dbg[(p*NUM_VCS+v)*2+:2] = state_q[p][v];
                if (idle) begin
                    enc                = VW'(v);
                    cnt                = cnt + FCW'(1);
                    next_free_valid[p] = 1'b1;
                end
            end
            next_free_vc[p*VW+:VW]    = enc;
            free_vc_count[p*FCW+:FCW] = cnt;
        end
    end

    assign err_sticky = err_q;

endmodule

// File: tb/tb_vc_state_tracker.sv
// Bench for vc_state_tracker: directed table of single-cycle vectors,
// an asynchronous mid-traffic reset, and randomized traffic checked every
// cycle against a behavioural model of the VC lifecycle and credit rules.
module tb_vc_state_tracker;

    localparam int NP  = 5;
    localparam int NV  = 4;
    localparam int BD  = 4;
    localparam int VW  = 2;
    localparam int FCW = 3;

    localparam int M_IDLE  = 0;
    localparam int M_BUSY  = 1;
    localparam int M_DRAIN = 2;
    localparam int M_ROOM  = 3;

    logic              clk;
    logic              rst_n;
    logic [NP-1:0]     alloc_valid;
    logic [NP*VW-1:0]  alloc_vc;
    logic [NP-1:0]     send_valid;
    logic [NP*VW-1:0]  send_vc;
    logic [NP-1:0]     send_tail;
    logic [NP-1:0]     cred_valid;
    logic [NP*VW-1:0]  cred_vc;
    logic [NP-1:0]     cred_free;
    logic [NP*NV-1:0]  vc_available;
    logic [NP*NV-1:0]  credit_avail;
    logic [NP*VW-1:0]  next_free_vc;
    logic [NP-1:0]     next_free_valid;
    logic [NP*FCW-1:0] free_vc_count;
    logic [NP-1:0]     err_sticky;
    logic [NP*NV*2-1:0] vc_state_dbg;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: lifecycle per VC as M_IDLE/M_BUSY/M_DRAIN, credit count, sticky error.
    int mst   [NP][NV];
    int mcred [NP][NV];
    bit merr  [NP];

    typedef struct {
        logic [4:0]  av;
        logic [9:0]  avc;
        logic [4:0]  sv;
        logic [9:0]  svc;
        logic [4:0]  st;
        logic [4:0]  cv;
        logic [9:0]  cvc;
        logic [4:0]  cf;
        logic [19:0] e_va;
        logic [19:0] e_ca;
        logic [9:0]  e_nfv;
        logic [4:0]  e_nfvld;
        logic [4:0]  e_err;
    } vec_t;

    vec_t tbl[$];

    vc_state_tracker #(.NUM_PORTS(NP), .NUM_VCS(NV), .BUF_DEPTH(BD)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .alloc_valid     (alloc_valid),
        .alloc_vc        (alloc_vc),
        .send_valid      (send_valid),
        .send_vc         (send_vc),
        .send_tail       (send_tail),
        .cred_valid      (cred_valid),
        .cred_vc         (cred_vc),
        .cred_free       (cred_free),
        .vc_available    (vc_available),
        .credit_avail    (credit_avail),
        .next_free_vc    (next_free_vc),
        .next_free_valid (next_free_valid),
        .free_vc_count   (free_vc_count),
        .err_sticky      (err_sticky),
        .vc_state_dbg    (vc_state_dbg)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int p = 0; p < NP; p++) begin
            for (int v = 0; v < NV; v++) begin
                mst[p][v]   = M_IDLE;
                mcred[p][v] = BD;
            end
            merr[p] = 1'b0;
        end
    endtask

    // Apply one clock edge's worth of events to the model, from the inputs currently driven.
    task automatic model_step();
        for (int p = 0; p < NP; p++) begin
            int a_id;
            int s_id;
            int c_id;
            a_id = int'(alloc_vc[p*VW+:VW]);
            s_id = int'(send_vc[p*VW+:VW]);
            c_id = int'(cred_vc[p*VW+:VW]);
            for (int v = 0; v < NV; v++) begin
                bit a;
                bit s;
                bit c;
                bit f;
                int ns;
                int nc;
                a  = alloc_valid[p] && (a_id == v);
                s  = send_valid[p] && (s_id == v);
                c  = cred_valid[p] && (c_id == v);
                f  = c && cred_free[p];
                ns = mst[p][v];
                if (a) begin
                    if (mst[p][v] == M_IDLE) ns = M_BUSY;
                    else merr[p] = 1'b1;
                end
                if (s) begin
                    if (mst[p][v] == M_BUSY) begin
                        if (send_tail[p]) ns = M_DRAIN;
                    end else merr[p] = 1'b1;
                end
                if (f) begin
                    if (mst[p][v] == M_DRAIN) ns = M_IDLE;
                    else merr[p] = 1'b1;
                end
                mst[p][v] = ns;
                nc = mcred[p][v] + int'(c) - int'(s);
                if (nc > BD || nc < 0) merr[p] = 1'b1;
                else mcred[p][v] = nc;
            end
        end
    endtask

    // Compare every output against what the model says the registered state implies.
    task automatic check_model(input string tag);
        logic [NP*NV-1:0]  e_va;
        logic [NP*NV-1:0]  e_ca;
        logic [NP*VW-1:0]  e_nfv;
        logic [NP-1:0]     e_nfvld;
        logic [NP*FCW-1:0] e_cnt;
        logic [NP-1:0]     e_err;
        e_va = '0; e_ca = '0; e_nfv = '0; e_nfvld = '0; e_cnt = '0; e_err = '0;
        for (int p = 0; p < NP; p++) begin
            int first;
            int cnt;
            first = -1;
            cnt   = 0;
            for (int v = 0; v < NV; v++) begin
                e_va[p*NV+v] = (mst[p][v] == M_IDLE);
                e_ca[p*NV+v] = (mcred[p][v] > 0);
                if (mst[p][v] == M_IDLE) begin
                    cnt++;
                    if (first < 0) first = v;
                end
            end
            e_nfvld[p]            = (first >= 0);
            e_nfv[p*VW+:VW]       = (first >= 0) ? VW'(first) : '0;
            e_cnt[p*FCW+:FCW]     = FCW'(cnt);
            e_err[p]              = merr[p];
        end
        chk({tag, ".vc_available"},    32'(vc_available),    32'(e_va));
        chk({tag, ".credit_avail"},    32'(credit_avail),    32'(e_ca));
        chk({tag, ".next_free_vc"},    32'(next_free_vc),    32'(e_nfv));
        chk({tag, ".next_free_valid"}, 32'(next_free_valid), 32'(e_nfvld));
        chk({tag, ".free_vc_count"},   32'(free_vc_count),   32'(e_cnt));
        chk({tag, ".err_sticky"},      32'(err_sticky),      32'(e_err));
    endtask

    // Driver: hold one cycle of events across a posedge, then check 1 time unit later.
    task automatic drive(input logic [4:0] av, input logic [9:0] avc,
                         input logic [4:0] sv, input logic [9:0] svc, input logic [4:0] st,
                         input logic [4:0] cv, input logic [9:0] cvc, input logic [4:0] cf,
                         input string tag);
        alloc_valid = av; alloc_vc = avc;
        send_valid  = sv; send_vc  = svc; send_tail = st;
        cred_valid  = cv; cred_vc  = cvc; cred_free = cf;
        @(posedge clk);
        model_step();
        #1;
        check_model(tag);
    endtask

    task automatic check_reset_values(input string tag);
        chk({tag, ".rst_va"},    32'(vc_available),    32'h000FFFFF);
        chk({tag, ".rst_ca"},    32'(credit_avail),    32'h000FFFFF);
        chk({tag, ".rst_nfv"},   32'(next_free_vc),    32'h0);
        chk({tag, ".rst_nfvld"}, 32'(next_free_valid), 32'h1F);
        chk({tag, ".rst_cnt"},   32'(free_vc_count),   32'h4924);
        chk({tag, ".rst_err"},   32'(err_sticky),      32'h0);
    endtask

    task automatic add(input logic [4:0] av, input logic [9:0] avc,
                       input logic [4:0] sv, input logic [9:0] svc, input logic [4:0] st,
                       input logic [4:0] cv, input logic [9:0] cvc, input logic [4:0] cf,
                       input logic [19:0] e_va, input logic [19:0] e_ca,
                       input logic [9:0] e_nfv, input logic [4:0] e_nfvld,
                       input logic [4:0] e_err);
        vec_t e;
        e.av = av; e.avc = avc; e.sv = sv; e.svc = svc; e.st = st;
        e.cv = cv; e.cvc = cvc; e.cf = cf;
        e.e_va = e_va; e.e_ca = e_ca; e.e_nfv = e_nfv; e.e_nfvld = e_nfvld; e.e_err = e_err;
        tbl.push_back(e);
    endtask

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            string nm;
            nm = $sformatf("%s[%0d]", tag, i);
            drive(tbl[i].av, tbl[i].avc, tbl[i].sv, tbl[i].svc, tbl[i].st,
                  tbl[i].cv, tbl[i].cvc, tbl[i].cf, nm);
            chk({nm, ".tbl_va"},    32'(vc_available),    32'(tbl[i].e_va));
            chk({nm, ".tbl_ca"},    32'(credit_avail),    32'(tbl[i].e_ca));
            chk({nm, ".tbl_nfv"},   32'(next_free_vc),    32'(tbl[i].e_nfv));
            chk({nm, ".tbl_nfvld"}, 32'(next_free_valid), 32'(tbl[i].e_nfvld));
            chk({nm, ".tbl_err"},   32'(err_sticky),      32'(tbl[i].e_err));
        end
        // Port 0 fully allocated, others untouched.
        chk({tag, ".tbl_count"}, 32'(free_vc_count), 32'h4920);
    endtask

    // Asynchronous reset between clock edges, with traffic still on the inputs.
    task automatic mid_reset(input string tag);
        alloc_valid = 5'h1F; alloc_vc = 10'h155;
        send_valid  = 5'h1F; send_vc  = 10'h2AA; send_tail = 5'h0A;
        cred_valid  = 5'h1F; cred_vc  = 10'h0F0; cred_free = 5'h11;
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_reset_values({tag, ".async"});
        check_model({tag, ".async"});
        alloc_valid = '0; send_valid = '0; cred_valid = '0;
        send_tail = '0; cred_free = '0;
        @(posedge clk);
        #1;
        check_reset_values({tag, ".held"});
        rst_n = 1'b1;
    endtask

    // Random VC of a port: usually one whose model condition makes the event legal.
    function automatic int pick(input int p, input int mode);
        int cand[$];
        for (int v = 0; v < NV; v++) begin
            if (mode == M_ROOM) begin
                if (mcred[p][v] < BD) cand.push_back(v);
            end else if (mst[p][v] == mode) cand.push_back(v);
        end
        if (cand.size() == 0 || $urandom_range(0, 7) == 0) return int'($urandom_range(0, NV - 1));
        return cand[$urandom_range(0, cand.size() - 1)];
    endfunction

    task automatic random_cycle(input int cyc);
        logic [4:0] av, sv, st, cv, cf;
        logic [9:0] avc, svc, cvc;
        av = '0; sv = '0; st = '0; cv = '0; cf = '0; avc = '0; svc = '0; cvc = '0;
        for (int p = 0; p < NP; p++) begin
            if ($urandom_range(0, 3) == 0) begin
                av[p] = 1'b1;
                avc[p*VW+:VW] = VW'(pick(p, M_IDLE));
            end
            if ($urandom_range(0, 2) == 0) begin
                sv[p] = 1'b1;
                svc[p*VW+:VW] = VW'(pick(p, M_BUSY));
                st[p] = ($urandom_range(0, 2) == 0);
            end
            if ($urandom_range(0, 2) == 0) begin
                cv[p] = 1'b1;
                if ($urandom_range(0, 1) == 0) begin
                    cvc[p*VW+:VW] = VW'(pick(p, M_DRAIN));
                    cf[p] = 1'b1;
                end else begin
                    cvc[p*VW+:VW] = VW'(pick(p, M_ROOM));
                end
            end
        end
        drive(av, avc, sv, svc, st, cv, cvc, cf, $sformatf("rnd%0d", cyc));
    endtask

    initial begin
        rst_n = 1'b0;
        alloc_valid = '0; alloc_vc = '0; send_valid = '0; send_vc = '0; send_tail = '0;
        cred_valid = '0; cred_vc = '0; cred_free = '0;
        model_reset();

        //   av    avc     sv    svc     st    cv    cvc     cf    va         ca         nfv     nfvld  err
        add(5'h00, 10'h000, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFFF, 20'hFFFFF, 10'h000, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFFF, 20'hFFFFF, 10'h000, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFFF, 20'hFFFFF, 10'h000, 5'h1F, 5'h00);
        // Port 2: alloc VC0, four body flits drain its credits.
        add(5'h04, 10'h000, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h04, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h04, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h04, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h04, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFEFF, 20'hFFEFF, 10'h010, 5'h1F, 5'h00);
        // Two credits back, then send+credit together (stays 2), then two sends empty it again.
        add(5'h00, 10'h000, 5'h00, 10'h000, 5'h00, 5'h04, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h00, 10'h000, 5'h00, 5'h04, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h04, 10'h000, 5'h00, 5'h04, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h04, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFEFF, 20'hFFFFF, 10'h010, 5'h1F, 5'h00);
        add(5'h00, 10'h000, 5'h04, 10'h000, 5'h04, 5'h00, 10'h000, 5'h00, 20'hFFEFF, 20'hFFEFF, 10'h010, 5'h1F, 5'h00);
        // cred_free returns VC0 of port 2 to IDLE.
        add(5'h00, 10'h000, 5'h00, 10'h000, 5'h00, 5'h04, 10'h000, 5'h04, 20'hFFFFF, 20'hFFFFF, 10'h000, 5'h1F, 5'h00);
        // Port 0: allocate all four VCs, then a fifth alloc to VC3.
        add(5'h01, 10'h000, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFFE, 20'hFFFFF, 10'h001, 5'h1F, 5'h00);
        add(5'h01, 10'h001, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFFC, 20'hFFFFF, 10'h002, 5'h1F, 5'h00);
        add(5'h01, 10'h002, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFF8, 20'hFFFFF, 10'h003, 5'h1F, 5'h00);
        add(5'h01, 10'h003, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFF0, 20'hFFFFF, 10'h000, 5'h1E, 5'h00);
        add(5'h01, 10'h003, 5'h00, 10'h000, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFF0, 20'hFFFFF, 10'h000, 5'h1E, 5'h01);
        // Port 1 credit overflow on VC2; port 3 send to IDLE VC1.
        add(5'h00, 10'h000, 5'h00, 10'h000, 5'h00, 5'h02, 10'h008, 5'h00, 20'hFFFF0, 20'hFFFFF, 10'h000, 5'h1E, 5'h03);
        add(5'h00, 10'h000, 5'h08, 10'h040, 5'h00, 5'h00, 10'h000, 5'h00, 20'hFFFF0, 20'hFFFFF, 10'h000, 5'h1E, 5'h0B);

        #12;
        check_reset_values("por");
        check_model("por");
        @(negedge clk);
        rst_n = 1'b1;

        run_table("tblA");
        mid_reset("mid");
        run_table("tblB");

        mid_reset("rmid0");
        for (int c = 0; c < 1200; c++) begin
            if (c % 300 == 299) mid_reset($sformatf("rmid%0d", c));
            else random_cycle(c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vc_state_tracker.md
Name: vc_state_tracker

Overview:
- Registered, per-output-port, per-VC state and credit tracker for the virtual channel router.
- Successor to the combinational availability updater. It tracks explicit VC ids instead of "first 1 from left", adds per-VC credit counters, a per-VC lifecycle state machine, simultaneous event resolution, a next-free-VC hint for VC allocation, and sticky protocol-error flags.
- Sits between VC allocation / switch traversal and the downstream credit-return channel of each output port.

Parameters:
- NUM_PORTS, 5, number of output ports.
- NUM_VCS, 4, VCs per output port.
- BUF_DEPTH, 4, downstream flit buffer depth per VC (max credits).
- VW, $clog2(NUM_VCS), VC id width (derived).
- CW, $clog2(BUF_DEPTH+1), credit counter width (derived).

Ports:
- clk  in  1  clock, posedge.
- rst_n  in  1  asynchronous active-low reset.
- alloc_valid  in  NUM_PORTS  VA granted a VC on port p this cycle.
- alloc_vc  in  NUM_PORTS*VW  granted VC id, port p at [p*VW+:VW].
- send_valid  in  NUM_PORTS  flit traversed switch to port p.
- send_vc  in  NUM_PORTS*VW  VC id of sent flit.
- send_tail  in  NUM_PORTS  sent flit is a tail (head+tail allowed).
- cred_valid  in  NUM_PORTS  downstream returned one credit on port p.
- cred_vc  in  NUM_PORTS*VW  VC id of returned credit.
- cred_free  in  NUM_PORTS  downstream VC released (tail left its buffer); qualified by cred_valid.
- vc_available  out  NUM_PORTS*NUM_VCS  VC [p*NUM_VCS+v] is IDLE.
- credit_avail  out  NUM_PORTS*NUM_VCS  credit count of VC is nonzero.
- next_free_vc  out  NUM_PORTS*VW  lowest-index IDLE VC per port; 0 if none.
- next_free_valid  out  NUM_PORTS  some VC on port p is IDLE.
- free_vc_count  out  NUM_PORTS*$clog2(NUM_VCS+1)  number of IDLE VCs per port.
- err_sticky  out  NUM_PORTS  protocol error seen on port p; cleared only by reset.

Behaviour:
- Per-VC state: 2-bit FSM {IDLE, ACTIVE, WAIT_FREE} plus CW-bit credit counter.
- Reset (async, immediate): all VCs IDLE, credits = BUF_DEPTH, err_sticky = 0.
  - Resulting outputs: vc_available all 1, credit_avail all 1, next_free_vc = 0, next_free_valid all 1, free_vc_count = NUM_VCS, err_sticky = 0.
  - Reset mid-operation discards all in-flight state.
- Timing: all state is updated at posedge clk. Outputs are combinational from registered state only, so an event in cycle t is visible in cycle t+1. No input-to-output combinational path.
- FSM transitions, evaluated per port with state as of the start of the cycle:
  - IDLE -> ACTIVE on alloc_valid to that VC.
  - ACTIVE -> WAIT_FREE on send_valid & send_tail to that VC.
  - WAIT_FREE -> IDLE on cred_valid & cred_free to that VC.
- Credit counter, per VC:
  - Decrement on send_valid.
  - Increment on cred_valid.
  - Both in the same cycle to the same VC: counter unchanged.
  - Increment at BUF_DEPTH: hold and flag error.
  - Decrement at 0: hold and flag error.
- Same-cycle events on different VCs of one port are independent. Ports are fully independent.
- Single-flit packet: alloc in cycle t, head+tail send in cycle ≥ t+1. A send to a non-ACTIVE VC is an error: FSM is unchanged, but the credit is still decremented if nonzero.
- Protocol errors set err_sticky[p] at the next edge; the offending event's FSM effect is dropped:
  - alloc to a VC not IDLE.
  - send to a VC not ACTIVE.
  - cred_free to a VC not WAIT_FREE. The credit part is still applied.
  - credit overflow or underflow.
- Alloc and cred_free to the same WAIT_FREE VC in one cycle: the free is applied (-> IDLE), the alloc is an error.
- next_free_vc: priority encoder, lowest index wins. free_vc_count is a popcount of IDLE VCs.
- VC ids ≥ NUM_VCS (non-power-of-2 NUM_VCS): event ignored, error flagged.

Test Plan:
- Reset, then idle 3 cycles -> vc_available = 20'hFFFFF, free_vc_count = 4 on all ports, next_free_vc = 0, credit_avail all 1, err_sticky = 0.
- Port 2: alloc VC0 at t; send 4 body flits VC0 t+1..t+4 -> vc_available[8] = 0 from t+1; next_free_vc[2] = 1; credit_avail[8] = 0 at t+5; err clear.
- Same port 2, VC0: cred_valid VC0 and send_valid VC0 in the same cycle with credits = 2 -> credits stay 2. Tail sent then cred_free -> WAIT_FREE then IDLE; vc_available[8] returns to 1 one cycle after cred_free.
- Port 0: alloc all 4 VCs over 4 cycles -> next_free_valid[0] = 0, free_vc_count[0] = 0. A fifth alloc to VC3 -> err_sticky[0] = 1 next cycle; other ports' err stay 0.
- Port 1 credit overflow: cred_valid to VC2 with 4 credits -> count stays 4, err_sticky[1] = 1. Port 3 send to IDLE VC1 -> err_sticky[3] = 1, vc_available[13] stays 1.
- Assert rst_n low mid-traffic, between clock edges -> all outputs return to reset values immediately without a clock edge; post-release behaviour is identical to the first scenario.
